// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the uart_alu frame parser.
package alu_pkg;

    localparam logic [7:0]  OP_ECHO       = 8'hEC;
    localparam logic [7:0]  OP_ADD        = 8'hA0;
    localparam logic [7:0]  OP_MUL        = 8'hA1;
    localparam logic [7:0]  OP_DIV        = 8'hA2;
    localparam logic [15:0] HDR_BYTES     = 16'd4;
    localparam logic [15:0] ALU_FRAME_LEN = 16'd12;

    typedef enum logic [2:0] {
        S_OP,
        S_RSVD,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_DRAIN
    } state_e;

    function automatic logic is_alu_op(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_word_packer.sv
// Packs payload bytes little-endian into 32-bit words held in a single
// output register with keep/last; unused upper lanes are always zero.
module alu_word_packer
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
);

    logic [23:0] acc;
    logic [1:0]  idx;
    logic [31:0] word_next;
    logic [3:0]  keep_next;

    // acc only ever holds lanes below idx, so OR-ing in the new byte is exact.
    always_comb begin
        word_next = {8'h00, acc} | ({24'h000000, byte_data} << {idx, 3'b000});
        keep_next = 4'h0;
        case (idx)
            2'd0:    keep_next = 4'h1;
            2'd1:    keep_next = 4'h3;
            2'd2:    keep_next = 4'h7;
            default: keep_next = 4'hF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc           <= '0;
            idx           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            // A load may coincide with a drain; the load wins and keeps valid high.
            if (byte_valid) begin
                if (idx == 2'd3 || byte_last) begin
                    m_axis_tdata  <= word_next;
                    m_axis_tkeep  <= keep_next;
                    m_axis_tlast  <= byte_last;
                    m_axis_tvalid <= 1'b1;
                    idx           <= '0;
                    acc           <= '0;
                end else begin
                    acc <= word_next[23:0];
                    idx <= idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_packet_rx.sv
// Host frame parser: validates the 4-byte header, drains bad frames and
// hands payload bytes to the word packer.
module alu_packet_rx
    import alu_pkg::*;
#(
    parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [7:0]  opcode_o,
    output logic [15:0] len_o,
    output logic        hdr_valid_o,
    output logic        err_bad_op_o,
    output logic        err_bad_len_o
);

    state_e      state;
    logic [15:0] rem;
    logic [7:0]  op_q;
    logic [7:0]  len_lo;
    logic        accept;
    logic [15:0] len_full;
    logic [15:0] rem_next;
    logic [16:0] over_diff;
    logic        too_short;
    logic        too_long;
    logic        op_known;

    // Handshake: a byte moves when s_axis_tvalid && s_axis_tready; a word moves
    // when m_axis_tvalid && m_axis_tready. Payload input stalls while the output
    // register is full and not being drained.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!reset_i) begin
            if (state == S_PAYLOAD) s_axis_tready = !m_axis_tvalid || m_axis_tready;
            else                    s_axis_tready = 1'b1;
        end
    end

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign len_full  = {s_axis_tdata, len_lo};
    assign rem_next  = len_full - HDR_BYTES;
    assign over_diff = {1'b0, MAX_LEN} - {1'b0, len_full};
    assign too_short = len_full < HDR_BYTES;
    assign too_long  = over_diff[16];
    assign op_known  = (op_q == OP_ECHO) || is_alu_op(op_q);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= S_OP;
            rem           <= '0;
            op_q          <= '0;
            len_lo        <= '0;
            opcode_o      <= '0;
            len_o         <= '0;
            hdr_valid_o   <= 1'b0;
            err_bad_op_o  <= 1'b0;
            err_bad_len_o <= 1'b0;
        end else begin
            hdr_valid_o   <= 1'b0;
            err_bad_op_o  <= 1'b0;
            err_bad_len_o <= 1'b0;
            if (accept) begin
                case (state)
                    S_OP: begin
                        op_q  <= s_axis_tdata;
                        state <= S_RSVD;
                    end
                    S_RSVD: state <= S_LEN_LO;
                    S_LEN_LO: begin
                        len_lo <= s_axis_tdata;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        if (too_short || too_long) begin
                            err_bad_len_o <= 1'b1;
                            state         <= S_OP;
                        end else begin
                            rem <= rem_next;
                            if (!op_known) begin
                                err_bad_op_o <= 1'b1;
                                state        <= (rem_next == 16'd0) ? S_OP : S_DRAIN;
                            end else if (is_alu_op(op_q) && len_full != ALU_FRAME_LEN) begin
                                err_bad_len_o <= 1'b1;
                                state         <= (rem_next == 16'd0) ? S_OP : S_DRAIN;
                            end else begin
                                hdr_valid_o <= 1'b1;
                                opcode_o    <= op_q;
                                len_o       <= len_full;
                                state       <= (rem_next == 16'd0) ? S_OP : S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD, S_DRAIN: begin
                        if (rem != 16'd0) rem <= rem - 16'd1;
                        if (rem <= 16'd1) state <= S_OP;
                    end
                    default: state <= S_OP;
                endcase
            end
        end
    end

    alu_word_packer u_packer (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .byte_data     (s_axis_tdata),
        .byte_valid    (accept && state == S_PAYLOAD),
        .byte_last     (rem == 16'd1),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_alu_packet_rx.sv
// Directed frames into alu_packet_rx; expected words and header events are
// queued at issue time and popped by an independent monitor.
module tb_alu_packet_rx;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [7:0]  opcode;
    logic [15:0] len;
    logic        hdr_valid, bad_op, bad_len;

    int tests = 0;
    int fails = 0;
    logic [36:0] exp_q[$];
    logic [26:0] ev_q[$];
    logic [7:0]  pay_q[$];
    logic [7:0]  last_op = '0;
    logic [15:0] last_len = '0;

    always #5 clk = ~clk;

    alu_packet_rx dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .opcode_o      (opcode),
        .len_o         (len),
        .hdr_valid_o   (hdr_valid),
        .err_bad_op_o  (bad_op),
        .err_bad_len_o (bad_len)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_hdr(input logic [7:0] op, input logic [15:0] l);
        ev_q.push_back({3'b100, op, l});
        last_op  = op;
        last_len = l;
    endtask

    task automatic exp_err(input logic bop, input logic blen);
        ev_q.push_back({1'b0, bop, blen, last_op, last_len});
    endtask

    task automatic exp_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({d, k, l});
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        #4;
        while (!s_tready && guard < 100) begin
            @(negedge clk);
            #4;
            guard++;
        end
        if (guard >= 100) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: byte %0h never accepted", b);
        end
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] l);
        send_byte(op);
        send_byte(8'h00);
        send_byte(l[7:0]);
        send_byte(l[15:8]);
        foreach (pay_q[i]) send_byte(pay_q[i]);
    endtask

    // Monitor: sample just before each rising edge, once inputs have settled.
    initial begin
        logic [36:0] ew;
        logic [26:0] ee;
        forever begin
            @(negedge clk);
            #4;
            if (!reset_i) begin
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL word_unexpected: got %0h keep %0h last %0b expected none",
                                 m_tdata, m_tkeep, m_tlast);
                    end else begin
                        ew = exp_q.pop_front();
                        check("word", {27'd0, m_tdata, m_tkeep, m_tlast}, {27'd0, ew});
                    end
                end
                if (hdr_valid || bad_op || bad_len) begin
                    if (ev_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL event_unexpected: got hdr/op/len %0b%0b%0b expected none",
                                 hdr_valid, bad_op, bad_len);
                    end else begin
                        ee = ev_q.pop_front();
                        check("event", {37'd0, hdr_valid, bad_op, bad_len, opcode, len}, {37'd0, ee});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_m", {27'd0, m_tvalid, m_tdata, m_tkeep, m_tlast}, 64'd0);
        check("reset_hdr", {35'd0, hdr_valid, bad_op, bad_len, opcode, len, s_tready}, 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);

        // Full-word echo
        exp_hdr(8'hEC, 16'd8);
        exp_word(32'hDEADBEEF, 4'hF, 1'b1);
        pay_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(8'hEC, 16'd8);

        // Partial word, then empty echo back to back
        exp_hdr(8'hEC, 16'd7);
        exp_word(32'h00332211, 4'h7, 1'b1);
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_frame(8'hEC, 16'd7);
        exp_hdr(8'hEC, 16'd4);
        pay_q.delete();
        send_frame(8'hEC, 16'd4);

        // ADD with downstream stalled for 20 cycles
        exp_hdr(8'hA0, 16'd12);
        exp_word(32'h00000001, 4'hF, 1'b0);
        exp_word(32'h00000002, 4'hF, 1'b1);
        pay_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        m_tready = 1'b0;
        fork
            send_frame(8'hA0, 16'd12);
            begin
                repeat (14) @(negedge clk);
                #1;
                check("stall_tready", {63'd0, s_tready}, 64'd0);
                repeat (6) @(negedge clk);
                m_tready = 1'b1;
            end
        join

        // Unknown opcode drains its payload; next frame parses normally
        exp_err(1'b1, 1'b0);
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(8'h55, 16'd10);
        exp_hdr(8'hEC, 16'd8);
        exp_word(32'h04030201, 4'hF, 1'b1);
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(8'hEC, 16'd8);

        // Length errors and priority
        exp_err(1'b0, 1'b1);
        pay_q.delete();
        send_frame(8'hEC, 16'd2);
        exp_err(1'b0, 1'b1);
        pay_q = '{8'h09, 8'h09, 8'h09, 8'h09};
        send_frame(8'hA1, 16'd8);
        exp_err(1'b1, 1'b0);
        pay_q.delete();
        send_frame(8'h55, 16'd4);
        exp_err(1'b0, 1'b1);
        send_frame(8'h55, 16'd0);
        exp_hdr(8'hEC, 16'd5);
        exp_word(32'h000000AA, 4'h1, 1'b1);
        pay_q = '{8'hAA};
        send_frame(8'hEC, 16'd5);

        // Multi-word echo ending in a 2-byte word
        exp_hdr(8'hEC, 16'd10);
        exp_word(32'h13121110, 4'hF, 1'b0);
        exp_word(32'h00001514, 4'h3, 1'b1);
        pay_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send_frame(8'hEC, 16'd10);

        // Reset after two payload bytes of a 12-byte echo
        exp_hdr(8'hEC, 16'd12);
        pay_q = '{8'hA1, 8'hB2};
        send_frame(8'hEC, 16'd12);
        reset_i = 1'b1;
        @(negedge clk);
        #1;
        check("midreset_m", {27'd0, m_tvalid, m_tdata, m_tkeep, m_tlast}, 64'd0);
        check("midreset_hdr", {35'd0, hdr_valid, bad_op, bad_len, opcode, len, s_tready}, 64'd0);
        @(negedge clk);
        reset_i  = 1'b0;
        last_op  = '0;
        last_len = '0;
        @(negedge clk);
        exp_hdr(8'hEC, 16'd8);
        exp_word(32'h78563412, 4'hF, 1'b1);
        pay_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_frame(8'hEC, 16'd8);

        repeat (10) @(negedge clk);
        check("word_q_empty", 64'(exp_q.size()), 64'd0);
        check("event_q_empty", 64'(ev_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_packet_rx.md
Name: alu_packet_rx

Overview:
- Front-end frame parser for uart_alu. Sits between the uart_rx AXI-stream byte output and the ALU/echo datapath.
- Consumes host frames: opcode byte, reserved byte, length LSB, length MSB, then payload.
- Length field = total frame bytes, 4-byte header included.
- Validates the header, reassembles the payload into little-endian 32-bit words with byte keep and last marker, and flags malformed frames.

Parameters:
- MAX_LEN, 16'hFFFF, largest legal length field; larger values are bad_len.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- s_axis_tdata  in  8  byte from uart_rx
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accepted when tvalid&&tready
- m_axis_tdata  out  32  payload word; first received byte in [7:0]
- m_axis_tkeep  out  4  valid byte lanes, lsb-contiguous
- m_axis_tlast  out  1  last word of frame
- m_axis_tvalid  out  1  word valid
- m_axis_tready  in  1  downstream ready
- opcode_o  out  8  latched opcode, stable from hdr_valid_o until the next frame's LEN_HI
- len_o  out  16  latched length field, same stability as opcode_o
- hdr_valid_o  out  1  1-cycle pulse, cycle after a good header's LEN_HI byte is accepted
- err_bad_op_o  out  1  1-cycle pulse: unknown opcode
- err_bad_len_o  out  1  1-cycle pulse: illegal length for opcode

Behaviour:
- Reset values: all outputs 0. FSM goes to S_OP. Accumulator, byte index and remaining count are cleared.
- Reset mid-frame: partial frame discarded. No tlast or error is emitted. The next byte is parsed as an opcode.
- FSM states: S_OP, S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_DRAIN.
- Every state advances only on an accepted byte.
- Header states (S_OP, S_RSVD, S_LEN_LO, S_LEN_HI): s_axis_tready=1.
- Reserved byte: accepted, value ignored.
- Header check on the LEN_HI accept, with len = {msb, lsb}. Checks apply in priority order:
  1. len<4 or len>MAX_LEN: bad_len pulse, go to S_OP, nothing drained.
  2. Unknown opcode: bad_op pulse. Go to S_DRAIN with rem=len-4, or to S_OP if rem=0.
  3. ALU opcode with len!=12: bad_len pulse. Go to S_DRAIN with rem=len-4, or to S_OP if rem=0.
  4. Otherwise: latch opcode_o/len_o, pulse hdr_valid_o. Go to S_PAYLOAD with rem=len-4, or to S_OP if rem=0 (echo with empty payload, no words emitted).
- S_DRAIN: s_axis_tready=1. Decrement rem per accepted byte; go to S_OP after the accept that makes rem=0. No m_axis output.
- S_PAYLOAD, readiness: s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - Conservative rule: the input stalls whenever the output register is full and not draining.
- S_PAYLOAD, per accepted byte:
  - Byte goes into accumulator lane idx; idx increments mod 4 and rem decrements.
  - When idx==3 or rem==1: the output register loads accumulator-plus-byte the next cycle.
  - Load sets tkeep = (1<<(idx+1))-1, tlast = (rem==1), m_axis_tvalid=1. idx resets to 0.
  - Unused lanes are driven 0.
- Output register: m_axis_tvalid stays 1 and data stays stable until m_axis_tready. A load and a drain in the same cycle are legal (back-to-back words).
- End of frame: after the tlast byte is accepted, FSM returns to S_OP. The next frame's header bytes may be accepted while the final word still waits on m_axis.
- Latency: last byte of a word accepted at cycle N → m_axis_tvalid at N+1.
- Arithmetic: rem is a 16-bit unsigned counter; it is never decremented below 0.
- Error pulses and hdr_valid_o never assert in the same cycle.

Decomposition:
- Package alu_pkg:
  - Opcode constants: OP_ECHO=8'hEC, OP_ADD=8'hA0, OP_MUL=8'hA1, OP_DIV=8'hA2.
  - HDR_BYTES=4; ALU_FRAME_LEN=12.
  - State enum typedef.
- Optional sub-module alu_word_packer: byte accumulator plus output skid register with keep/last.

Test Plan:
- Echo, len=8, payload EF BE AD DE → hdr_valid_o, opcode_o=EC, len_o=8; one word tdata=32'hDEADBEEF, tkeep=4'hF, tlast=1.
- Echo, len=7, payload 11 22 33 → one word 32'h00332211, tkeep=4'h7, tlast=1. Back-to-back second echo frame (len=4) → hdr_valid_o only, no word.
- ADD, len=12, bytes 01 00 00 00 02 00 00 00 with m_axis_tready held low 20 cycles → s_axis_tready drops and no byte is lost. On release: words 32'h1 (tlast=0), then 32'h2 (tlast=1).
- Opcode 55, len=10 → err_bad_op_o pulse and 6 bytes drained. A following echo len=8 frame parses correctly.
- Echo, len=2 → err_bad_len_o pulse, immediate return to S_OP. MUL, len=8 → err_bad_len_o, 4 bytes drained.
- reset_i asserted after 2 payload bytes of an echo len=12 frame → all outputs 0 and no tlast. Next echo len=8 frame is correct.
